i2s_tx: RTL



---
 rtl/i2s_tx.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/i2s_tx.sv
// I2S transmitter: 2-entry stereo FIFO, BCLK/LRCK generation, MSB-first serializer.
// Optional macro I2S_TX_UNDERRUN_REPEAT_EN repeats the last good pair on underrun.
module i2s_tx #(
    parameter int BCLK_HALF = 1,
    parameter int SLOT_BITS = 32
) (
    input  logic        clk_audio,
    input  logic        rst_n,
    input  logic [23:0] audio_in_left,
    input  logic [23:0] audio_in_right,
    input  logic        audio_in_valid,
    output logic        audio_in_ready,
    input  logic        tx_enable,
    input  logic        underrun_clr,
    output logic        i2s_bclk,
    output logic        i2s_lrck,
    output logic        i2s_sdata,
    output logic        frame_strobe,
    output logic        underrun,
    output logic [1:0]  fifo_level,
    output logic        tx_active
);
    localparam int FRAME = 2 * SLOT_BITS;
    localparam int BW = $clog2(FRAME);
    localparam int DW = (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1;
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
    localparam logic [BW-1:0] LAST_BIT = BW'(FRAME - 1);
    localparam logic [BW-1:0] RIGHT_START = BW'(SLOT_BITS);
    localparam logic [DW-1:0] DIV_TC = DW'(BCLK_HALF - 1);

    logic [1:0]    state, state_nx;
    logic [DW-1:0] div_cnt;
    logic [BW-1:0] bit_cnt, bit_nx;
    logic          bclk, lrck, sdata;
    logic [47:0]   fifo_mem [2];
    logic          wr_ptr, rd_ptr;
    logic [1:0]    count;
    logic [23:0]   frame_l, frame_r;
    logic [23:0]   last_l, last_r;
    logic          empty, full, push, pop;
    logic          tick, fall, wrap, stop, load;

    function automatic logic bit_at(
        input logic [BW-1:0] k,
        input logic [23:0]   l,
        input logic [23:0]   r
    );
        int ki;
        logic [4:0] idx;
        ki = int'(k);
        idx = '0;
        bit_at = 1'b0;
        if (ki >= 1 && ki <= 24) begin
            idx = 5'(24 - ki);
            bit_at = l[idx];
        end else if (ki >= SLOT_BITS + 1 && ki <= SLOT_BITS + 24) begin
            idx = 5'(24 + SLOT_BITS - ki);
            bit_at = r[idx];
        end
    endfunction

    always_comb begin
        empty = (count == 2'd0);
        full  = (count == 2'd2);
        push  = audio_in_valid && !full;
        tick  = (div_cnt == DIV_TC);
        fall  = tick && bclk;
        wrap  = fall && (bit_cnt == LAST_BIT);
        // Draining with no re-request ends at the wrap without loading.
        stop  = (state == DRAIN) && !tx_enable && wrap;
        load  = ((state == IDLE) && tx_enable) ||
                ((state != IDLE) && wrap && !stop);
        pop   = load && !empty;
        bit_nx = wrap ? '0 : bit_cnt + 1'b1;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (tx_enable) state_nx = RUN;
            RUN:     if (!tx_enable) state_nx = DRAIN;
            DRAIN: begin
                if (tx_enable) state_nx = RUN;
                else if (wrap) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk_audio or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            div_cnt <= '0;
            bit_cnt <= '0;
            bclk    <= 1'b0;
            lrck    <= 1'b0;
            sdata   <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == IDLE || stop) begin
                div_cnt <= '0;
                bit_cnt <= '0;
                bclk    <= 1'b0;
                lrck    <= 1'b0;
                sdata   <= 1'b0;
            end else if (tick) begin
                div_cnt <= '0;
                bclk    <= ~bclk;
                if (bclk) begin
                    bit_cnt <= bit_nx;
                    lrck    <= (bit_nx >= RIGHT_START);
                    sdata   <= bit_at(bit_nx, frame_l, frame_r);
                end
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_audio) begin
        if (push) fifo_mem[wr_ptr] <= {audio_in_left, audio_in_right};
    end

    always_ff @(posedge clk_audio or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop) rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

    always_ff @(posedge clk_audio or negedge rst_n) begin
        if (!rst_n) begin
            frame_l      <= '0;
            frame_r      <= '0;
            last_l       <= '0;
            last_r       <= '0;
            frame_strobe <= 1'b0;
            underrun     <= 1'b0;
        end else begin
            frame_strobe <= load;
            if (pop) begin
                {frame_l, frame_r} <= fifo_mem[rd_ptr];
                {last_l, last_r}   <= fifo_mem[rd_ptr];
            end else if (load) begin
`ifdef I2S_TX_UNDERRUN_REPEAT_EN
                frame_l <= last_l;
                frame_r <= last_r;
`else
                frame_l <= '0;
                frame_r <= '0;
`endif
            end
            if (load && empty) underrun <= 1'b1;
            else if (underrun_clr) underrun <= 1'b0;
        end
    end

    assign audio_in_ready = !full;
    assign fifo_level     = count;
    assign tx_active      = (state != IDLE);
    assign i2s_bclk       = bclk;
    assign i2s_lrck       = lrck;
    assign i2s_sdata      = sdata;
endmodule
